// File: rtl/mmu_tile_sequencer_pkg.sv
// Shared control definitions for the MMU tile sequencer and weight-FIFO controller.
package tpu_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_REQ  = 3'd1,
        LOAD_WAIT = 3'd2,
        FEED      = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } seq_state_e;

    // Phase counter must hold 0..2*width-2 without wrapping.
    function automatic int unsigned calc_cnt_w(input int unsigned width);
        return $clog2(2 * width);
    endfunction

    // Row count spans 0..width inclusive.
    function automatic int unsigned calc_nr_w(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mmu_tile_sequencer_if.sv
// Host / weight-FIFO / input-FIFO signal bundle of the tile sequencer.
interface mmu_tile_sequencer_if
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    localparam int unsigned NR_W = calc_nr_w(WIDTH);

    logic              start;
    logic              abort;
    logic [NR_W-1:0]   num_rows;
    logic              weight_stagger;
    logic              wfifo_active;
    logic              wfifo_stagger;
    logic              wfifo_done;
    logic [WIDTH-1:0]  data_en;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, num_rows, weight_stagger, wfifo_done,
        input  wfifo_active, wfifo_stagger, data_en, busy, done
    );

    modport slave (
        input  start, abort, num_rows, weight_stagger, wfifo_done,
        output wfifo_active, wfifo_stagger, data_en, busy, done
    );

endinterface

// File: rtl/mmu_tile_sequencer_stagger_window.sv
// Diagonal wavefront decoder: lane i is enabled while i <= t < i + num_rows.
module stagger_window
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = calc_cnt_w(WIDTH),
    parameter int unsigned NR_W  = calc_nr_w(WIDTH)
) (
    input  logic [CNT_W-1:0] i_t,
    input  logic [NR_W-1:0]  i_num_rows,
    output logic [WIDTH-1:0] o_mask_c
);

    always_comb begin
        o_mask_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_mask_c[i] = (i_t >= CNT_W'(i)) &&
                          (i_t < (CNT_W'(i) + CNT_W'(i_num_rows)));
        end
    end

endmodule

// File: rtl/mmu_tile_sequencer.sv
// Tile sequencer: weight-load handshake, diagonal input feed, pipeline drain, done pulse.
module mmu_tile_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    mmu_tile_sequencer_if.slave  bus
);

    localparam int unsigned      CNT_W      = calc_cnt_w(WIDTH);
    localparam int unsigned      NR_W       = calc_nr_w(WIDTH);
    localparam logic [NR_W-1:0]  ROWS_MAX   = NR_W'(WIDTH);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FEED_TAIL  = CNT_W'(WIDTH - 2);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [NR_W-1:0]  r_rows;
    logic [NR_W-1:0]  w_rows_nxt;
    logic             r_stagger;
    logic             w_stagger_nxt;
    logic [CNT_W-1:0] w_feed_last;
    logic [WIDTH-1:0] w_mask;

    logic             r_wfifo_active;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_data_en;

    assign w_feed_last = CNT_W'(r_rows) + FEED_TAIL;

    // Next-state, counter and config-latch logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rows_nxt    = r_rows;
        w_stagger_nxt = r_stagger;

        if ((r_state != IDLE) && bus.abort) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_rows_nxt    = '0;
            w_stagger_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        w_state_nxt   = LOAD_REQ;
                        w_cnt_nxt     = '0;
                        w_rows_nxt    = (bus.num_rows > ROWS_MAX) ? ROWS_MAX : bus.num_rows;
                        w_stagger_nxt = bus.weight_stagger;
                    end
                end
                LOAD_REQ: begin
                    w_state_nxt = LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    if (bus.wfifo_done) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_rows != '0) ? FEED : DRAIN;
                    end
                end
                FEED: begin
                    if (r_cnt == w_feed_last) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (r_cnt == DRAIN_LAST) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    w_state_nxt   = IDLE;
                    w_rows_nxt    = '0;
                    w_stagger_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_rows_nxt    = '0;
                    w_stagger_nxt = 1'b0;
                end
            endcase
        end
    end

    // Mask is decoded from next-cycle counter so data_en can be registered.
    stagger_window #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .NR_W  (NR_W)
    ) u_window (
        .i_t        (w_cnt_nxt),
        .i_num_rows (w_rows_nxt),
        .o_mask_c   (w_mask)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rows    <= '0;
            r_stagger <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rows    <= w_rows_nxt;
            r_stagger <= w_stagger_nxt;
        end
    end

    // Output registers track the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wfifo_active <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_data_en      <= '0;
        end else begin
            r_wfifo_active <= (w_state_nxt == LOAD_REQ);
            r_busy         <= (w_state_nxt != IDLE);
            r_done         <= (w_state_nxt == DONE);
            r_data_en      <= (w_state_nxt == FEED) ? w_mask : '0;
        end
    end

    assign bus.wfifo_active  = r_wfifo_active;
    assign bus.wfifo_stagger = r_stagger;
    assign bus.data_en       = r_data_en;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Self-checking bench for mmu_tile_sequencer: timestamp-based reference model plus directed literal checks.
module tb_mmu_tile_sequencer;
    import tpu_ctrl_pkg::*;

    localparam int unsigned W  = 16;
    localparam int          WI = 16;

    logic clk;
    logic rst;

    mmu_tile_sequencer_if #(.WIDTH(W)) bus ();

    mmu_tile_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: tile described by its accept edge, load-done edge and row count.
    int e      = 0;
    bit m_busy = 1'b0;
    int m_s    = 0;
    int m_c    = -1;
    int m_r    = 0;
    bit m_g    = 1'b0;

    int n_act  = 0;
    int n_feed = 0;

    logic [15:0] short_exp [18] = '{
        16'h0001, 16'h0003, 16'h0007, 16'h000E, 16'h001C, 16'h0038,
        16'h0070, 16'h00E0, 16'h01C0, 16'h0380, 16'h0700, 16'h0E00,
        16'h1C00, 16'h3800, 16'h7000, 16'hE000, 16'hC000, 16'h8000
    };

    function automatic int feed_len(input int r);
        return (r > 0) ? (r + WI - 1) : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_update();
        int rows;
        e++;
        rows = int'(bus.num_rows);
        if (rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.start && !bus.abort) begin
                m_busy = 1'b1;
                m_s    = e;
                m_c    = -1;
                m_r    = (rows > WI) ? WI : rows;
                m_g    = bus.weight_stagger;
            end
        end else if (bus.abort) begin
            m_busy = 1'b0;
        end else if (m_c < 0) begin
            if ((e >= m_s + 2) && bus.wfifo_done) m_c = e;
        end else if (e == m_c + feed_len(m_r) + WI + 1) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic model_compare();
        int          k;
        int          t;
        logic [15:0] em;
        logic        ea;
        logic        ed;
        k  = e + 1;
        em = '0;
        ea = m_busy && (k == m_s + 1);
        ed = m_busy && (m_c >= 0) && (k == m_c + feed_len(m_r) + WI + 1);
        if (m_busy && m_c >= 0) begin
            t = k - m_c - 1;
            if (t >= 0 && t < feed_len(m_r)) begin
                for (int i = 0; i < WI; i++) em[i] = (t >= i) && (t < i + m_r);
            end
        end
        chk("model_busy",    32'(bus.busy),          32'(m_busy));
        chk("model_active",  32'(bus.wfifo_active),  32'(ea));
        chk("model_stagger", 32'(bus.wfifo_stagger), 32'(m_busy ? m_g : 1'b0));
        chk("model_data_en", 32'(bus.data_en),       32'(em));
        chk("model_done",    32'(bus.done),          32'(ed));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_compare();
        if (bus.wfifo_active) n_act++;
        if (bus.data_en != '0) n_feed++;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(name, 32'(bus.done), 32'd1);
    endtask

    initial begin
        logic [31:0] acc;
        int          n;

        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.num_rows       = '0;
        bus.weight_stagger = 1'b0;
        bus.wfifo_done     = 1'b0;
        tick();
        tick();
        chk("rst_busy",    32'(bus.busy),          32'd0);
        chk("rst_active",  32'(bus.wfifo_active),  32'd0);
        chk("rst_stagger", 32'(bus.wfifo_stagger), 32'd0);
        chk("rst_data_en", 32'(bus.data_en),       32'd0);
        chk("rst_done",    32'(bus.done),          32'd0);
        rst = 1'b0;
        tick();

        // wfifo_done high while idle changes nothing
        bus.wfifo_done = 1'b1;
        repeat (3) tick();
        chk("wdone_idle_busy", 32'(bus.busy), 32'd0);
        bus.wfifo_done = 1'b0;
        tick();

        // Full tile, staggered weights, load done 5 cycles after request
        n_act = 0; n_feed = 0;
        bus.start = 1'b1; bus.num_rows = 5'd16; bus.weight_stagger = 1'b1;
        tick();
        bus.start = 1'b0; bus.num_rows = '0; bus.weight_stagger = 1'b0;
        chk("full_active",  32'(bus.wfifo_active),  32'd1);
        chk("full_stagger", 32'(bus.wfifo_stagger), 32'd1);
        repeat (4) tick();
        bus.wfifo_done = 1'b1;
        tick();
        bus.wfifo_done = 1'b0;
        chk("full_t0", 32'(bus.data_en), 32'h0001);
        for (int t = 1; t <= 30; t++) begin
            if (t == 5) bus.start = 1'b1;
            if (t == 9) bus.wfifo_done = 1'b1;
            tick();
            bus.start = 1'b0;
            bus.wfifo_done = 1'b0;
            if (t == 1)  chk("full_t1",  32'(bus.data_en), 32'h0003);
            if (t == 15) chk("full_t15", 32'(bus.data_en), 32'hFFFF);
            if (t == 30) chk("full_t30", 32'(bus.data_en), 32'h8000);
        end
        acc = '0;
        repeat (16) begin
            tick();
            acc = acc | 32'(bus.data_en) | 32'(bus.done);
        end
        chk("full_drain_quiet", acc, 32'd0);
        tick();
        chk("full_done",        32'(bus.done),          32'd1);
        chk("full_stag_in_done", 32'(bus.wfifo_stagger), 32'd1);
        tick();
        chk("full_idle_busy",   32'(bus.busy),          32'd0);
        chk("full_idle_stag",   32'(bus.wfifo_stagger), 32'd0);
        chk("full_one_active",  32'(n_act),             32'd1);
        chk("full_feed_cycles", 32'(n_feed),            32'd31);

        // Short tile; wfifo_done already high during LOAD_REQ
        n_act = 0; n_feed = 0;
        bus.start = 1'b1; bus.num_rows = 5'd3;
        tick();
        bus.start = 1'b0;
        bus.wfifo_done = 1'b1;
        tick();
        tick();
        bus.wfifo_done = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) tick();
            chk($sformatf("short_t%0d", k), 32'(bus.data_en), 32'(short_exp[k]));
        end
        tick();
        chk("short_drain", 32'(bus.data_en), 32'd0);
        wait_done("short_done", 40);
        tick();
        chk("short_feed_cycles", 32'(n_feed), 32'd18);
        chk("short_one_active",  32'(n_act),  32'd1);

        // Zero rows: straight to drain
        n_feed = 0;
        bus.start = 1'b1; bus.num_rows = '0; bus.weight_stagger = 1'b1;
        tick();
        bus.start = 1'b0; bus.weight_stagger = 1'b0;
        tick();
        bus.wfifo_done = 1'b1;
        tick();
        bus.wfifo_done = 1'b0;
        acc = '0;
        n = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            acc = acc | 32'(bus.data_en);
            tick();
            n++;
        end
        chk("zero_done_latency", 32'(n),      32'd17);
        chk("zero_no_enable",    acc,         32'd0);
        chk("zero_feed_cycles",  32'(n_feed), 32'd0);
        tick();

        // Oversized num_rows saturates to WIDTH
        n_feed = 0;
        bus.start = 1'b1; bus.num_rows = 5'd25;
        tick();
        bus.start = 1'b0;
        tick();
        bus.wfifo_done = 1'b1;
        tick();
        bus.wfifo_done = 1'b0;
        wait_done("sat_done", 80);
        tick();
        chk("sat_feed_cycles", 32'(n_feed), 32'd31);

        // Abort at FEED t=7
        bus.start = 1'b1; bus.num_rows = 5'd16; bus.weight_stagger = 1'b1;
        tick();
        bus.start = 1'b0; bus.weight_stagger = 1'b0;
        tick();
        bus.wfifo_done = 1'b1;
        tick();
        bus.wfifo_done = 1'b0;
        repeat (7) tick();
        chk("abort_pre_t7", 32'(bus.data_en), 32'h00FF);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_data_en", 32'(bus.data_en),       32'd0);
        chk("abort_busy",    32'(bus.busy),          32'd0);
        chk("abort_done",    32'(bus.done),          32'd0);
        chk("abort_stagger", 32'(bus.wfifo_stagger), 32'd0);
        acc = '0;
        repeat (20) begin
            tick();
            acc = acc | 32'(bus.done);
        end
        chk("abort_no_done", acc, 32'd0);

        // Abort and start together in IDLE: start dropped
        bus.start = 1'b1; bus.abort = 1'b1; bus.num_rows = 5'd4;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abort_start_busy", 32'(bus.busy), 32'd0);
        tick();

        // Normal tile after abort
        n_act = 0; n_feed = 0;
        bus.start = 1'b1; bus.num_rows = 5'd4; bus.weight_stagger = 1'b1;
        tick();
        bus.start = 1'b0; bus.weight_stagger = 1'b0;
        chk("post_abort_active", 32'(bus.wfifo_active), 32'd1);
        tick();
        bus.wfifo_done = 1'b1;
        tick();
        bus.wfifo_done = 1'b0;
        wait_done("post_abort_done", 60);
        tick();
        chk("post_abort_feed", 32'(n_feed), 32'd19);
        chk("post_abort_act",  32'(n_act),  32'd1);

        // Reset during DRAIN with start/abort also asserted
        bus.start = 1'b1; bus.num_rows = 5'd2;
        tick();
        bus.start = 1'b0;
        tick();
        bus.wfifo_done = 1'b1;
        tick();
        bus.wfifo_done = 1'b0;
        repeat (16) tick();
        repeat (3) tick();
        chk("rst_mid_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1; bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        chk("rst_mid_busy",    32'(bus.busy),          32'd0);
        chk("rst_mid_active",  32'(bus.wfifo_active),  32'd0);
        chk("rst_mid_stagger", 32'(bus.wfifo_stagger), 32'd0);
        chk("rst_mid_data_en", 32'(bus.data_en),       32'd0);
        chk("rst_mid_done",    32'(bus.done),          32'd0);
        bus.abort = 1'b0;
        tick();
        chk("rst_start_ignored", 32'(bus.busy), 32'd0);
        rst = 1'b0; bus.start = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
